// File: rtl/sniff_mm_writer.sv
// ---------------------------------------------------------------------------
// sniff_mm_writer
//
// Purpose:
//   Downstream stage of the Ethernet sniffer. The sniffer's memory-write
//   stream (write_enable / addr_out / data_out) is buffered in a small FIFO.
//   Each entry is then replayed as an Avalon-MM master write, and the
//   avm_waitrequest stall from the slave is honoured. Pushes that arrive
//   while the FIFO is full are counted, so software can detect loss caused
//   by back-pressure.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   clear            synchronous flush of queued (not yet issued) entries
//   wr_en            push request from the sniffer
//   wr_addr          push address (BASE_ADDR is added, wraps mod 2^ADDR_W)
//   wr_data          push data
//   fifo_full        registered, FIFO holds DEPTH entries
//   fifo_count       registered, number of queued entries
//   avm_address      Avalon-MM write address
//   avm_write        Avalon-MM write strobe
//   avm_writedata    Avalon-MM write data
//   avm_waitrequest  Avalon-MM slave stall
//   drop_count       saturating count of pushes rejected while full
//   overflow         sticky, set on the first dropped push
//   busy             avm_write or a non-empty FIFO
// ---------------------------------------------------------------------------
module sniff_mm_writer #(
    parameter int                DEPTH     = 16,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]        avm_address,
    output logic                     avm_write,
    output logic [DATA_W-1:0]        avm_writedata,
    input  logic                     avm_waitrequest,
    output logic [15:0]              drop_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    // Storage: address and data held side by side per entry.
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic [0:0]        r_state;
    logic              r_avm_write;
    logic [ADDR_W-1:0] r_avm_address;
    logic [DATA_W-1:0] r_avm_writedata;
    logic [15:0]       r_drop_count;
    logic              r_overflow;

    logic              w_push;
    logic              w_drop;
    logic              w_can_issue;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;

    // A push coinciding with clear is discarded silently (neither stored
    // nor counted as a drop). While full, a push is dropped even if a pop
    // frees a slot in the same cycle, because there is no bypass path.
    assign w_push = wr_en && !r_full && !clear;
    assign w_drop = wr_en &&  r_full && !clear;

    // A new entry may be loaded onto the bus from IDLE, or from WRITE once
    // the current transfer is accepted (back-to-back). Clear blocks pops so
    // that only the write already on the bus survives a flush.
    assign w_can_issue = (r_state == S_IDLE) || !avm_waitrequest;
    assign w_pop       = w_can_issue && (r_count != '0) && !clear;

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else begin
            if (w_push) w_count_next = w_count_next + CNT_ONE;
            if (w_pop)  w_count_next = w_count_next - CNT_ONE;
        end
    end

    // Storage has no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= wr_addr + BASE_ADDR;
            r_mem_data[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and drop accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (clear) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Avalon-MM master FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_avm_write     <= 1'b0;
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_avm_address   <= r_mem_addr[r_rd_ptr];
                        r_avm_writedata <= r_mem_data[r_rd_ptr];
                        r_avm_write     <= 1'b1;
                        r_state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Bus outputs are held untouched while the slave stalls.
                    if (!avm_waitrequest) begin
                        if (w_pop) begin
                            r_avm_address   <= r_mem_addr[r_rd_ptr];
                            r_avm_writedata <= r_mem_data[r_rd_ptr];
                        end else begin
                            r_avm_write <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_avm_write <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_full     = r_full;
    assign fifo_count    = r_count;
    assign avm_address   = r_avm_address;
    assign avm_write     = r_avm_write;
    assign avm_writedata = r_avm_writedata;
    assign drop_count    = r_drop_count;
    assign overflow      = r_overflow;
    assign busy          = r_avm_write || (r_count != '0);

endmodule

// File: tb/tb_sniff_mm_writer.sv
// ---------------------------------------------------------------------------
// tb_sniff_mm_writer
//
// Purpose:
//   Scoreboard bench for sniff_mm_writer (DEPTH=16, BASE_ADDR=32'h1000).
//   Stimulus pushes the expected {address, data} of each accepted write into
//   a queue. A negedge monitor pops and compares whenever a transfer
//   completes (avm_write=1, avm_waitrequest=0). It also checks that the bus
//   stays stable during stalls.
// ---------------------------------------------------------------------------
module tb_sniff_mm_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        fifo_full;
    logic [4:0]  fifo_count;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [15:0] drop_count;
    logic        overflow;
    logic        busy;

    sniff_mm_writer #(
        .DEPTH     (16),
        .DATA_W    (32),
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_1000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .fifo_full       (fifo_full),
        .fifo_count      (fifo_count),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .drop_count      (drop_count),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp    = 0;
    int          n_err    = 0;
    int          n_writes = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic [63:0] mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_write", 32'(avm_write), 32'd1);
                chk("hold_addr", avm_address, prev_addr);
                chk("hold_data", avm_writedata, prev_data);
            end
            if (avm_write && !avm_waitrequest) begin
                n_writes++;
                $display("write %0d: addr=%h data=%h", n_writes, avm_address, avm_writedata);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                             avm_address, avm_writedata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", avm_address, mon_e[63:32]);
                    chk("wr_data", avm_writedata, mon_e[31:0]);
                end
            end
            prev_stall = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_a, input bit accept);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (accept) exp_q.push_back({exp_a, d});
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            step();
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: busy=1 after %0d cycles, expected 0", maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        avm_waitrequest = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_avm_write", 32'(avm_write), 32'd0);
        chk("rst_avm_address", avm_address, 32'h0);
        chk("rst_avm_writedata", avm_writedata, 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Single write: latency of one edge, strobe for one cycle
        w0 = n_writes;
        push(32'h10, 32'h641225EB, 32'h1010, 1'b1);
        step();
        chk("single_write", 32'(avm_write), 32'd1);
        chk("single_addr", avm_address, 32'h1010);
        chk("single_data", avm_writedata, 32'h641225EB);
        step();
        chk("single_write_low", 32'(avm_write), 32'd0);
        chk("single_count", 32'(n_writes - w0), 32'd1);

        // Back-pressure hold for 4 cycles, then back-to-back
        avm_waitrequest = 1'b1;
        w0 = n_writes;
        push(32'h20, 32'hAAAA0001, 32'h1020, 1'b1);
        push(32'h24, 32'hAAAA0002, 32'h1024, 1'b1);
        repeat (3) step();
        chk("bp_stalled_data", avm_writedata, 32'hAAAA0001);
        avm_waitrequest = 1'b0;
        step();
        chk("bp_no_gap_write", 32'(avm_write), 32'd1);
        chk("bp_no_gap_data", avm_writedata, 32'hAAAA0002);
        step();
        chk("bp_done_write", 32'(avm_write), 32'd0);
        chk("bp_count", 32'(n_writes - w0), 32'd2);

        // Full / drop: 20 pushes while stalled, 17 accepted
        avm_waitrequest = 1'b1;
        w0 = n_writes;
        for (int i = 0; i < 20; i++) begin
            push(32'h100 + 32'(4 * i), 32'hD000_0000 + 32'(i), 32'h1100 + 32'(4 * i), i < 17);
            if (i == 15) chk("full_before_17", 32'(fifo_full), 32'd0);
            if (i == 16) chk("full_after_17", 32'(fifo_full), 32'd1);
        end
        chk("full_drop_count", 32'(drop_count), 32'd3);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_fifo_count", 32'(fifo_count), 32'd16);
        avm_waitrequest = 1'b0;
        drain(60);
        chk("full_write_count", 32'(n_writes - w0), 32'd17);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Wrap: 40 words through the ring with a toggling stall; addresses
        // 32'hFFFF_F000 + 4i plus BASE 32'h1000 wrap to 4i.
        w0 = n_writes;
        for (int i = 0; i < 40; i++) begin
            avm_waitrequest = ~avm_waitrequest;
            push(32'hFFFF_F000 + 32'(4 * i), 32'h5000_0000 + 32'(i), 32'(4 * i), 1'b1);
            avm_waitrequest = ~avm_waitrequest;
            step();
        end
        avm_waitrequest = 1'b0;
        drain(100);
        chk("wrap_write_count", 32'(n_writes - w0), 32'd40);
        chk("wrap_drop_count", 32'(drop_count), 32'd3);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clear with a stalled write and 5 queued entries
        avm_waitrequest = 1'b1;
        w0 = n_writes;
        push(32'h200, 32'h0000_00C0, 32'h1200, 1'b1);
        for (int i = 1; i < 6; i++) push(32'h200 + 32'(4 * i), 32'hC0 + 32'(i), 32'h0, 1'b0);
        chk("clr_count_before", 32'(fifo_count), 32'd5);
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 32'h300;
        wr_data = 32'hDEAD_BEEF;
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        chk("clr_count_after", 32'(fifo_count), 32'd0);
        chk("clr_bus_kept", 32'(avm_write), 32'd1);
        chk("clr_bus_addr", avm_address, 32'h1200);
        chk("clr_drop_same", 32'(drop_count), 32'd3);
        avm_waitrequest = 1'b0;
        step();
        chk("clr_write_low", 32'(avm_write), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd1);
        chk("clr_busy", 32'(busy), 32'd0);
        repeat (4) step();
        chk("clr_write_count", 32'(n_writes - w0), 32'd1);

        // Reset mid-stream: stalled write plus 3 queued, all abandoned
        avm_waitrequest = 1'b1;
        w0 = n_writes;
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 32'hE0 + 32'(i), 32'h0, 1'b0);
        chk("mrst_count_before", 32'(fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_avm_write", 32'(avm_write), 32'd0);
        chk("mrst_fifo_count", 32'(fifo_count), 32'd0);
        chk("mrst_drop_count", 32'(drop_count), 32'd0);
        chk("mrst_overflow", 32'(overflow), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (10) step();
        chk("mrst_no_reissue", 32'(n_writes - w0), 32'd0);
        chk("mrst_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
